pwm_timer_ctrl: RTL and testbench
=================================

// Module: pwm_timer_ctrl
//
// PURPOSE
//  Sequencer and configuration front-end for pwm_gen.
//  - Owns the time base: prescaler plus up/down counter, driving pwm_gen.count_val.
//  - Double-buffers period/compare1/compare2/functions, committing them only at a
//    counter wrap, so pwm_gen never sees a mid-period configuration change.
//  - Gates pwm_gen.pwm_en; provides continuous and one-shot modes.
//
// PARAMETERS
//  CNT_W    16  counter, period and compare width
//  PRESC_W   8  prescaler width
//
// PORTS
//  clk            in   1        peripheral clock
//  rst            in   1        reset; synchronous, active-high
//  cfg_en         in   1        level; 1 = run timer, 0 = stop
//  cfg_oneshot    in   1        1 = stop after first wrap
//  cfg_dir        in   1        0 = count up, 1 = count down
//  cfg_prescale   in   PRESC_W  counter advances every cfg_prescale+1 clk cycles
//  cfg_period     in   CNT_W    staged period
//  cfg_compare1   in   CNT_W    staged compare1
//  cfg_compare2   in   CNT_W    staged compare2
//  cfg_functions  in   8        staged functions
//  cfg_load       in   1        pulse; request shadow commit at next wrap
//  cfg_cnt_clr    in   1        pulse; restart counter and prescaler
//  count_val      out  CNT_W    to pwm_gen.count_val
//  period         out  CNT_W    shadow, to pwm_gen
//  compare1       out  CNT_W    shadow, to pwm_gen
//  compare2       out  CNT_W    shadow, to pwm_gen
//  functions      out  8        shadow, to pwm_gen
//  pwm_en         out  1        to pwm_gen.pwm_en
//  wrap_pulse     out  1        one-cycle strobe on every counter wrap
//  load_pending   out  1        commit requested, not yet applied
//  done           out  1        one-shot completed
//
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  - All outputs are registered.
//  - rst=1 at a clk edge: FSM=IDLE; count_val, prescaler and all shadows = 0;
//    pwm_en, wrap_pulse, load_pending and done = 0.
//  - Start value: 0 when cfg_dir=0; shadow period when cfg_dir=1.
//  FSM {IDLE, RUN, DONE}
//   IDLE: pwm_en=0; count_val holds its value.
//     cfg_en=1 -> RUN. On the same edge, copy all cfg_* values into the shadows
//     unconditionally and clear load_pending.
//   RUN: pwm_en=1.
//     cfg_en=0 -> IDLE next edge; count_val and prescaler freeze. Re-enabling resumes.
//   DONE: pwm_en=0; done=1; count_val = start value.
//     cfg_en=0 -> IDLE, done=0.
//  Prescaler (RUN only): counts 0..cfg_prescale, then returns to 0.
//   A tick occurs on the cycle it equals cfg_prescale; cfg_prescale=0 gives a tick every clk.
//  Counter, on each tick (shadow period P is inclusive):
//   - Up: count_val==P -> 0 (wrap), else +1.
//   - Down: count_val==0 -> P (wrap), else -1.
//   - P=0: count_val stays 0; every tick is a wrap.
//  Wrap edge actions:
//   - wrap_pulse=1 for exactly one cycle.
//   - If load_pending: shadows <= cfg_* and load_pending <= 0. The new values are
//     visible with the first count of the new period.
//   - If cfg_oneshot=1: -> DONE.
//  cfg_load:
//   - Sets load_pending.
//   - In the same cycle as a wrap: the commit uses the current cfg_* values and
//     load_pending ends at 0.
//   - In IDLE: absorbed by the unconditional copy on entry to RUN.
//  cfg_cnt_clr (highest priority after rst, any state):
//   - count_val <= start value; prescaler <= 0.
//   - Not a wrap: no wrap_pulse, no commit.
//   - In DONE: also returns the FSM to RUN if cfg_en=1.
//  Arithmetic: unsigned, CNT_W bits; no overflow possible (compare against P).
//  rst mid-period overrides everything; pending loads are discarded.
//
// TESTING
//  1. prescale=0, up, P=4, en=1 -> count_val 0,1,2,3,4,0,...; wrap_pulse when 4->0;
//     pwm_en=1 one cycle after en.
//  2. prescale=2, up, P=3 -> each count value held 3 clks; wrap every 12 clks.
//  3. Running with P=9, cmp1=3; mid-period set cfg_period=5, cfg_compare1=2, pulse cfg_load
//     -> shadows unchanged until 9->0 wrap; next period counts 0..5; load_pending 1->0 at wrap.
//  4. oneshot=1, down, P=3 -> count_val 3,2,1,0, then DONE: pwm_en=0, done=1, count_val=3;
//     drop en -> IDLE, done=0.
//  5. cfg_load in the same cycle as a wrap, and cfg_cnt_clr at count_val=2
//     -> commit happens and load_pending=0; clear gives count_val=0, no wrap_pulse.
//  6. rst asserted mid-run with load_pending=1 -> next cycle all outputs 0, FSM=IDLE.

Source files
------------

// File: rtl/pwm_timer_ctrl.sv
// Time base and double-buffered configuration front-end for pwm_gen.
// Prescaled up/down counter; shadow registers commit only on a counter wrap.
module pwm_timer_ctrl #(
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cfg_en,
    input  logic               i_cfg_oneshot,
    input  logic               i_cfg_dir,
    input  logic [PRESC_W-1:0] i_cfg_prescale,
    input  logic [CNT_W-1:0]   i_cfg_period,
    input  logic [CNT_W-1:0]   i_cfg_compare1,
    input  logic [CNT_W-1:0]   i_cfg_compare2,
    input  logic [7:0]         i_cfg_functions,
    input  logic               i_cfg_load,
    input  logic               i_cfg_cnt_clr,
    output logic [CNT_W-1:0]   o_count_val,
    output logic [CNT_W-1:0]   o_period,
    output logic [CNT_W-1:0]   o_compare1,
    output logic [CNT_W-1:0]   o_compare2,
    output logic [7:0]         o_functions,
    output logic               o_pwm_en,
    output logic               o_wrap_pulse,
    output logic               o_load_pending,
    output logic               o_done
);

    // state | meaning
    // IDLE  | stopped, counter holds, pwm disabled
    // RUN   | prescaler and counter advance, pwm enabled
    // DONE  | one-shot finished, counter parked at start value
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0]   r_count;
    logic [PRESC_W-1:0] r_presc;
    logic [CNT_W-1:0]   r_period;
    logic [CNT_W-1:0]   r_compare1;
    logic [CNT_W-1:0]   r_compare2;
    logic [7:0]         r_functions;
    logic               r_pwm_en;
    logic               r_wrap_pulse;
    logic               r_load_pending;
    logic               r_done;

    logic               w_entry;
    logic               w_counting;
    logic               w_tick;
    logic               w_at_end;
    logic               w_wrap;
    logic               w_copy;
    logic [CNT_W-1:0]   w_period_nxt;
    logic [CNT_W-1:0]   w_start;

    assign w_entry    = (r_state == ST_IDLE) && i_cfg_en;
    assign w_counting = (r_state == ST_RUN) && i_cfg_en && !i_cfg_cnt_clr;
    // >= keeps a lowered prescale or period from running the full width before wrapping
    assign w_tick     = w_counting && (r_presc >= i_cfg_prescale);
    assign w_at_end   = i_cfg_dir ? (r_count == '0) : (r_count >= r_period);
    assign w_wrap     = w_tick && w_at_end;
    assign w_copy     = w_entry || (w_wrap && (r_load_pending || i_cfg_load));
    // a down-count reload uses the period being committed on the same wrap
    assign w_period_nxt = w_copy ? i_cfg_period : r_period;
    assign w_start      = i_cfg_dir ? r_period : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_cfg_en) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (!i_cfg_en)                     w_state_nxt = ST_IDLE;
                else if (w_wrap && i_cfg_oneshot)  w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (!i_cfg_en)          w_state_nxt = ST_IDLE;
                else if (i_cfg_cnt_clr) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count        <= '0;
            r_presc        <= '0;
            r_period       <= '0;
            r_compare1     <= '0;
            r_compare2     <= '0;
            r_functions    <= '0;
            r_pwm_en       <= 1'b0;
            r_wrap_pulse   <= 1'b0;
            r_load_pending <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_pwm_en     <= (w_state_nxt == ST_RUN);
            r_done       <= (w_state_nxt == ST_DONE);
            r_wrap_pulse <= w_wrap;

            if (i_cfg_cnt_clr) begin
                r_count <= w_start;
                r_presc <= '0;
            end else if (w_counting) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
                if (w_tick) begin
                    if (w_wrap)         r_count <= i_cfg_dir ? w_period_nxt : '0;
                    else if (i_cfg_dir) r_count <= r_count - 1'b1;
                    else                r_count <= r_count + 1'b1;
                end
            end

            if (w_copy) begin
                r_period    <= i_cfg_period;
                r_compare1  <= i_cfg_compare1;
                r_compare2  <= i_cfg_compare2;
                r_functions <= i_cfg_functions;
            end
            r_load_pending <= w_copy ? 1'b0 : (r_load_pending || i_cfg_load);
        end
    end

    assign o_count_val    = r_count;
    assign o_period       = r_period;
    assign o_compare1     = r_compare1;
    assign o_compare2     = r_compare2;
    assign o_functions    = r_functions;
    assign o_pwm_en       = r_pwm_en;
    assign o_wrap_pulse   = r_wrap_pulse;
    assign o_load_pending = r_load_pending;
    assign o_done         = r_done;

endmodule

// File: tb/tb_pwm_timer_ctrl.sv
// Self-checking bench for pwm_timer_ctrl: directed scenarios plus randomized
// runs predicted arithmetically from tick counts.
module tb_pwm_timer_ctrl;
    localparam int CW = 16;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst, en, oneshot, dir, load, clr;
    logic [PW-1:0] prescale;
    logic [CW-1:0] period, cmp1, cmp2;
    logic [7:0]    func;

    logic [CW-1:0] o_count, o_period, o_cmp1, o_cmp2;
    logic [7:0]    o_func;
    logic          o_pwm_en, o_wrap, o_pend, o_done;

    int checks = 0;
    int errors = 0;

    pwm_timer_ctrl #(.CNT_W(CW), .PRESC_W(PW)) dut (
        .i_clk(clk), .i_rst(rst), .i_cfg_en(en), .i_cfg_oneshot(oneshot),
        .i_cfg_dir(dir), .i_cfg_prescale(prescale), .i_cfg_period(period),
        .i_cfg_compare1(cmp1), .i_cfg_compare2(cmp2), .i_cfg_functions(func),
        .i_cfg_load(load), .i_cfg_cnt_clr(clr),
        .o_count_val(o_count), .o_period(o_period), .o_compare1(o_cmp1),
        .o_compare2(o_cmp2), .o_functions(o_func), .o_pwm_en(o_pwm_en),
        .o_wrap_pulse(o_wrap), .o_load_pending(o_pend), .o_done(o_done)
    );

    always #5 clk = ~clk;

    task automatic tk;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; oneshot = 1'b0; dir = 1'b0; load = 1'b0; clr = 1'b0;
        prescale = '0; period = 16'd7; cmp1 = 16'd3; cmp2 = 16'd5; func = 8'h3C;
        tk; tk;
        rst = 1'b0;
        checks++; if (o_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", o_count); end
        checks++; if ({o_period, o_cmp1, o_cmp2, o_func} !== '0) begin errors++; $display("FAIL reset_shadows got %h exp 0", {o_period, o_cmp1, o_cmp2, o_func}); end
        checks++; if ({o_pwm_en, o_wrap, o_pend, o_done} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {o_pwm_en, o_wrap, o_pend, o_done}); end
    endtask

    task automatic test_basic_up;
        prescale = '0; dir = 1'b0; period = 16'd4; cmp1 = 16'd1; cmp2 = 16'd2; func = 8'hA5;
        en = 1'b1; tk;
        checks++; if (o_pwm_en !== 1'b1) begin errors++; $display("FAIL up_pwm_en_entry got %b exp 1", o_pwm_en); end
        checks++; if (o_count !== 16'd0) begin errors++; $display("FAIL up_count_entry got %0d exp 0", o_count); end
        checks++; if (o_period !== 16'd4 || o_func !== 8'hA5) begin errors++; $display("FAIL up_shadow_copy got %0d/%h exp 4/a5", o_period, o_func); end
        for (int k = 1; k <= 12; k++) begin
            tk;
            checks++; if (o_count !== 16'(k % 5)) begin errors++; $display("FAIL up_count k=%0d got %0d exp %0d", k, o_count, k % 5); end
            checks++; if (o_wrap !== 1'(k % 5 == 0)) begin errors++; $display("FAIL up_wrap k=%0d got %b exp %b", k, o_wrap, k % 5 == 0); end
        end
        en = 1'b0; tk;
        checks++; if (o_pwm_en !== 1'b0 || o_count !== 16'd2) begin errors++; $display("FAIL up_stop got en=%b cnt=%0d exp en=0 cnt=2", o_pwm_en, o_count); end
        tk;
        checks++; if (o_count !== 16'd2) begin errors++; $display("FAIL up_freeze got %0d exp 2", o_count); end
        en = 1'b1; tk;
        checks++; if (o_count !== 16'd2 || o_pwm_en !== 1'b1) begin errors++; $display("FAIL up_reenable got cnt=%0d en=%b exp 2/1", o_count, o_pwm_en); end
        tk;
        checks++; if (o_count !== 16'd3) begin errors++; $display("FAIL up_resume got %0d exp 3", o_count); end
        en = 1'b0; tk;
    endtask

    task automatic test_prescale;
        int n;
        period = 16'd3; prescale = 8'd2; en = 1'b1; tk;
        clr = 1'b1; tk; clr = 1'b0;
        checks++; if (o_count !== 16'd0 || o_wrap !== 1'b0) begin errors++; $display("FAIL presc_clr got cnt=%0d wrap=%b exp 0/0", o_count, o_wrap); end
        for (int k = 1; k <= 30; k++) begin
            tk;
            n = k / 3;
            checks++; if (o_count !== 16'(n % 4)) begin errors++; $display("FAIL presc_count k=%0d got %0d exp %0d", k, o_count, n % 4); end
            checks++; if (o_wrap !== 1'(k % 3 == 0 && n % 4 == 0)) begin errors++; $display("FAIL presc_wrap k=%0d got %b", k, o_wrap); end
        end
        en = 1'b0; tk;
    endtask

    task automatic test_shadow_load;
        int exp_cnt;
        prescale = '0; period = 16'd9; cmp1 = 16'd3; en = 1'b1; tk;
        clr = 1'b1; tk; clr = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 4) begin period = 16'd5; cmp1 = 16'd2; load = 1'b1; end
            else load = 1'b0;
            tk;
            exp_cnt = (k < 10) ? k : (k - 10) % 6;
            checks++; if (o_count !== 16'(exp_cnt)) begin errors++; $display("FAIL load_count k=%0d got %0d exp %0d", k, o_count, exp_cnt); end
            checks++; if (o_period !== ((k < 10) ? 16'd9 : 16'd5) || o_cmp1 !== ((k < 10) ? 16'd3 : 16'd2)) begin errors++; $display("FAIL load_shadow k=%0d got p=%0d c1=%0d", k, o_period, o_cmp1); end
            checks++; if (o_pend !== 1'(k >= 4 && k < 10)) begin errors++; $display("FAIL load_pending k=%0d got %b", k, o_pend); end
            checks++; if (o_wrap !== 1'(k == 10 || k == 16)) begin errors++; $display("FAIL load_wrap k=%0d got %b", k, o_wrap); end
        end
        load = 1'b0; en = 1'b0; tk;
    endtask

    task automatic test_oneshot_down;
        dir = 1'b1; period = 16'd3; prescale = '0;
        for (int pass = 0; pass < 2; pass++) begin
            en = 1'b1; tk;
            oneshot = 1'b1; clr = 1'b1; tk; clr = 1'b0;
            checks++; if (o_count !== 16'd3) begin errors++; $display("FAIL os_start pass=%0d got %0d exp 3", pass, o_count); end
            for (int k = 1; k <= 3; k++) begin
                tk;
                checks++; if (o_count !== 16'(3 - k) || o_pwm_en !== 1'b1 || o_done !== 1'b0) begin errors++; $display("FAIL os_count k=%0d got cnt=%0d en=%b done=%b", k, o_count, o_pwm_en, o_done); end
            end
            tk;
            checks++; if (o_done !== 1'b1 || o_pwm_en !== 1'b0 || o_count !== 16'd3 || o_wrap !== 1'b1) begin errors++; $display("FAIL os_done got done=%b en=%b cnt=%0d wrap=%b", o_done, o_pwm_en, o_count, o_wrap); end
            tk;
            checks++; if (o_done !== 1'b1 || o_count !== 16'd3 || o_wrap !== 1'b0) begin errors++; $display("FAIL os_hold got done=%b cnt=%0d wrap=%b", o_done, o_count, o_wrap); end
            if (pass == 0) begin
                en = 1'b0; tk;
                checks++; if (o_done !== 1'b0 || o_pwm_en !== 1'b0) begin errors++; $display("FAIL os_exit got done=%b en=%b exp 0/0", o_done, o_pwm_en); end
            end else begin
                oneshot = 1'b0; clr = 1'b1; tk; clr = 1'b0;
                checks++; if (o_pwm_en !== 1'b1 || o_done !== 1'b0 || o_count !== 16'd3) begin errors++; $display("FAIL os_clr_restart got en=%b done=%b cnt=%0d", o_pwm_en, o_done, o_count); end
                tk;
                checks++; if (o_count !== 16'd2) begin errors++; $display("FAIL os_restart_count got %0d exp 2", o_count); end
                en = 1'b0; tk;
            end
        end
        dir = 1'b0; oneshot = 1'b0;
    endtask

    task automatic test_load_wrap_clr;
        period = 16'd4; cmp2 = 16'd2; prescale = '0; en = 1'b1; tk;
        clr = 1'b1; tk; clr = 1'b0;
        for (int k = 1; k <= 4; k++) tk;
        period = 16'd6; cmp2 = 16'd7; load = 1'b1; tk; load = 1'b0;
        checks++; if (o_count !== 16'd0 || o_wrap !== 1'b1) begin errors++; $display("FAIL lw_wrap got cnt=%0d wrap=%b", o_count, o_wrap); end
        checks++; if (o_period !== 16'd6 || o_cmp2 !== 16'd7 || o_pend !== 1'b0) begin errors++; $display("FAIL lw_commit got p=%0d c2=%0d pend=%b", o_period, o_cmp2, o_pend); end
        tk; tk;
        checks++; if (o_count !== 16'd2) begin errors++; $display("FAIL lw_count got %0d exp 2", o_count); end
        period = 16'd1; clr = 1'b1; tk; clr = 1'b0;
        checks++; if (o_count !== 16'd0 || o_wrap !== 1'b0 || o_period !== 16'd6) begin errors++; $display("FAIL lw_clr got cnt=%0d wrap=%b p=%0d", o_count, o_wrap, o_period); end
        en = 1'b0; tk;
        load = 1'b1; tk; load = 1'b0;
        checks++; if (o_pend !== 1'b1 || o_pwm_en !== 1'b0) begin errors++; $display("FAIL idle_load got pend=%b en=%b exp 1/0", o_pend, o_pwm_en); end
        en = 1'b1; tk;
        checks++; if (o_pend !== 1'b0 || o_period !== 16'd1) begin errors++; $display("FAIL idle_absorb got pend=%b p=%0d exp 0/1", o_pend, o_period); end
    endtask

    task automatic test_rst_mid_run;
        period = 16'd9; clr = 1'b1; tk; clr = 1'b0;
        load = 1'b1; tk; load = 1'b0;
        checks++; if (o_pend !== 1'b1 || o_count !== 16'd1) begin errors++; $display("FAIL rst_setup got pend=%b cnt=%0d exp 1/1", o_pend, o_count); end
        rst = 1'b1; tk; rst = 1'b0; en = 1'b0;
        checks++; if ({o_count, o_period, o_cmp1, o_cmp2, o_func} !== '0) begin errors++; $display("FAIL rst_data got %h exp 0", {o_count, o_period, o_cmp1, o_cmp2, o_func}); end
        checks++; if ({o_pwm_en, o_wrap, o_pend, o_done} !== 4'b0) begin errors++; $display("FAIL rst_flags got %b exp 0000", {o_pwm_en, o_wrap, o_pend, o_done}); end
        tk;
        checks++; if (o_pwm_en !== 1'b0 || o_count !== 16'd0) begin errors++; $display("FAIL rst_idle got en=%b cnt=%0d exp 0/0", o_pwm_en, o_count); end
    endtask

    // Each enabled cycle in RUN is one prescaler step; the count after n ticks
    // is n mod (P+1) going up, or P minus that going down.
    task automatic test_random;
        int p, s, k, n, exp_cnt;
        bit run_prev, en_now, counting, exp_wrap;
        for (int it = 0; it < 8; it++) begin
            en = 1'b0; tk;
            p = $urandom_range(0, 7); s = $urandom_range(0, 3);
            dir = 1'($urandom_range(0, 1));
            period = 16'(p); prescale = 8'(s);
            cmp1 = 16'($urandom); cmp2 = 16'($urandom); func = 8'($urandom);
            en = 1'b1; tk;
            clr = 1'b1; tk; clr = 1'b0;
            k = 0; run_prev = 1'b1;
            for (int c = 0; c < 40; c++) begin
                en_now = ($urandom_range(0, 7) != 0);
                en = en_now;
                tk;
                counting = en_now && run_prev;
                if (counting) k++;
                n = k / (s + 1);
                exp_cnt = dir ? p - (n % (p + 1)) : n % (p + 1);
                exp_wrap = counting && (k % (s + 1) == 0) && (n % (p + 1) == 0);
                checks++; if (o_count !== 16'(exp_cnt)) begin errors++; $display("FAIL rnd_count it=%0d c=%0d got %0d exp %0d", it, c, o_count, exp_cnt); end
                checks++; if (o_wrap !== exp_wrap) begin errors++; $display("FAIL rnd_wrap it=%0d c=%0d got %b exp %b", it, c, o_wrap, exp_wrap); end
                checks++; if (o_pwm_en !== en_now) begin errors++; $display("FAIL rnd_pwm_en it=%0d c=%0d got %b exp %b", it, c, o_pwm_en, en_now); end
                checks++; if (o_period !== 16'(p) || o_cmp1 !== cmp1 || o_cmp2 !== cmp2 || o_func !== func) begin errors++; $display("FAIL rnd_shadow it=%0d c=%0d got p=%0d c1=%0d", it, c, o_period, o_cmp1); end
                run_prev = en_now;
            end
        end
        en = 1'b0; dir = 1'b0; tk;
    endtask

    initial begin
        test_reset;
        test_basic_up;
        test_prescale;
        test_shadow_load;
        test_oneshot_down;
        test_load_wrap_clr;
        test_rst_mid_run;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
